// File: rtl/dmu_sii_inb_tracker_if.sv
// -----------------------------------------------------------------------------
// dmu_sii_inb_tracker_if
//
// Purpose : Bundles the DMU->SII inbound request bus and the SII->DMU write-ack
//           return into one interface, so that a passive observer can be
//           attached to the SII boundary with a single port.
//
// Parameters
//   DATA_W  data bus width (a multiple of 16)
//   PAR_W   parity bits, one per 16-bit lane
//
// Signals
//   dmu_sii_hdr_vld     header cycle qualifier
//   dmu_sii_reqbypass   bypass qualifier (Mondo vs PIO read return)
//   dmu_sii_datareq     header carries payload
//   dmu_sii_datareq16   payload is the 16-byte Mondo/PIO kind
//   dmu_sii_data        header or payload beat
//   dmu_sii_parity      even parity per 16-bit lane
//   sii_dmu_wrack_vld   DMA write credit return
//   sii_dmu_wrack_tag   tag of the returned credit
//
// Modports
//   master  drives every signal (the DMU/SII side, or a testbench)
//   slave   observes every signal (the tracker)
// -----------------------------------------------------------------------------
interface dmu_sii_inb_tracker_if #(
   parameter int DATA_W = 128,
   parameter int PAR_W  = DATA_W / 16
);

   logic              dmu_sii_hdr_vld;
   logic              dmu_sii_reqbypass;
   logic              dmu_sii_datareq;
   logic              dmu_sii_datareq16;
   logic [DATA_W-1:0] dmu_sii_data;
   logic [PAR_W-1:0]  dmu_sii_parity;
   logic              sii_dmu_wrack_vld;
   logic [3:0]        sii_dmu_wrack_tag;

   modport master (
      output dmu_sii_hdr_vld,
      output dmu_sii_reqbypass,
      output dmu_sii_datareq,
      output dmu_sii_datareq16,
      output dmu_sii_data,
      output dmu_sii_parity,
      output sii_dmu_wrack_vld,
      output sii_dmu_wrack_tag
   );

   modport slave (
      input  dmu_sii_hdr_vld,
      input  dmu_sii_reqbypass,
      input  dmu_sii_datareq,
      input  dmu_sii_datareq16,
      input  dmu_sii_data,
      input  dmu_sii_parity,
      input  sii_dmu_wrack_vld,
      input  sii_dmu_wrack_tag
   );

endinterface : dmu_sii_inb_tracker_if

// File: rtl/dmu_sii_inb_tracker.sv
// -----------------------------------------------------------------------------
// dmu_sii_inb_tracker
//
// Purpose : Passive tracker for the DMU->SII inbound request interface.
//           Decodes header cycles into read / write / Mondo / PIO-read-return
//           events, follows the fixed-length payload that trails write and
//           Mondo/PIO headers, counts outstanding DMA write credits against
//           SII write acks, and reports protocol violations both as one-cycle
//           pulses and as sticky status bits.
//
// Optional feature : define DMU_SII_INB_PARCHK_EN to enable the per-lane even
//           parity checker on header and payload cycles. Without it the
//           checker is not built and err_pulse[3] / err_sticky[3] are 0.
//
// Parameters
//   DATA_W    data bus width, multiple of 16, at least 80 (header fields)
//   PAR_W     parity bits, one per 16-bit lane
//   WR_BEATS  payload beats after a write header
//   MP_BEATS  payload beats after a Mondo or PIO header
//   CREDITS   maximum outstanding DMA writes
//   CNT_W     outstanding counter width, 2**CNT_W > CREDITS
//
// Ports
//   iol2clk          clock
//   rst              synchronous active-high reset
//   sii              observed bus (slave modport)
//   ev_rd/ev_wr/ev_mondo/ev_pio   header-decoded pulses
//   ev_wr_done/ev_mp_done         pulse after the last payload beat
//   hdr_tag          data[79:64] of the last accepted header
//   hdr_pa           data[39:0]  of the last accepted header
//   wr_outstanding   in-flight DMA writes
//   last_wrack_tag   tag of the most recent write ack
//   err_pulse        {parity, wrack_underflow, credit_overflow, hdr_in_payload}
//   err_sticky       OR-accumulated err_pulse, cleared only by rst
//
// All outputs are registered: every pulse appears the cycle after the input
// cycle that caused it and lasts exactly one cycle.
// -----------------------------------------------------------------------------
module dmu_sii_inb_tracker #(
   parameter int DATA_W   = 128,
   parameter int PAR_W    = DATA_W / 16,
   parameter int WR_BEATS = 4,
   parameter int MP_BEATS = 1,
   parameter int CREDITS  = 16,
   parameter int CNT_W    = 5
) (
   input  logic                 iol2clk,
   input  logic                 rst,
   dmu_sii_inb_tracker_if.slave sii,
   output logic                 ev_rd,
   output logic                 ev_wr,
   output logic                 ev_mondo,
   output logic                 ev_pio,
   output logic                 ev_wr_done,
   output logic                 ev_mp_done,
   output logic [15:0]          hdr_tag,
   output logic [39:0]          hdr_pa,
   output logic [CNT_W-1:0]     wr_outstanding,
   output logic [3:0]           last_wrack_tag,
   output logic [3:0]           err_pulse,
   output logic [3:0]           err_sticky
);

   // Error vector bit positions.
   localparam int ERR_HDR_IN_PAY = 0;
   localparam int ERR_CREDIT_OVF = 1;
   localparam int ERR_WRACK_UNF  = 2;
   localparam int ERR_PARITY     = 3;

   // The beat counter only has to hold the longer payload length minus one.
   localparam int MAX_BEATS = (WR_BEATS > MP_BEATS) ? WR_BEATS : MP_BEATS;
   localparam int BEAT_W    = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

   localparam logic [BEAT_W-1:0] WR_LOAD = BEAT_W'(WR_BEATS - 1);
   localparam logic [BEAT_W-1:0] MP_LOAD = BEAT_W'(MP_BEATS - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(CREDITS);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WR_PAY = 2'd1,
      ST_MP_PAY = 2'd2
   } state_e;

   // ---------------------------------------------------------------------------
   // State and registered outputs
   // ---------------------------------------------------------------------------
   state_e            state_q,      state_d;
   logic [BEAT_W-1:0] beat_cnt_q,   beat_cnt_d;

   logic              ev_rd_q,      ev_rd_d;
   logic              ev_wr_q,      ev_wr_d;
   logic              ev_mondo_q,   ev_mondo_d;
   logic              ev_pio_q,     ev_pio_d;
   logic              ev_wr_done_q, ev_wr_done_d;
   logic              ev_mp_done_q, ev_mp_done_d;
   logic [15:0]       hdr_tag_q,    hdr_tag_d;
   logic [39:0]       hdr_pa_q,     hdr_pa_d;
   logic [CNT_W-1:0]  wr_out_q,     wr_out_d;
   logic [3:0]        wrack_tag_q,  wrack_tag_d;
   logic [3:0]        err_pulse_q,  err_pulse_d;
   logic [3:0]        err_sticky_q, err_sticky_d;

   // ---------------------------------------------------------------------------
   // Header decode. A header only counts while the FSM is IDLE; during a
   // payload the same strobe is a protocol error and is otherwise ignored.
   // ---------------------------------------------------------------------------
   logic hdr_acc;
   logic hdr_rd;
   logic hdr_wr;
   logic hdr_mp;
   logic in_payload;

   assign in_payload = (state_q != ST_IDLE);
   assign hdr_acc    = sii.dmu_sii_hdr_vld && !in_payload;
   // {datareq, datareq16} = 00 or 01 both decode as a read.
   assign hdr_rd     = hdr_acc && !sii.dmu_sii_datareq;
   assign hdr_wr     = hdr_acc &&  sii.dmu_sii_datareq && !sii.dmu_sii_datareq16;
   assign hdr_mp     = hdr_acc &&  sii.dmu_sii_datareq &&  sii.dmu_sii_datareq16;

   // ---------------------------------------------------------------------------
   // Parity checker (optional)
   // ---------------------------------------------------------------------------
   logic par_err;

`ifdef DMU_SII_INB_PARCHK_EN
   logic par_mismatch;

   always_comb begin
      par_mismatch = 1'b0;
      for (int i = 0; i < PAR_W; i++) begin
         if (sii.dmu_sii_parity[i] != ^sii.dmu_sii_data[16*i +: 16]) begin
            par_mismatch = 1'b1;
         end
      end
   end

   // Checked on every header cycle and every payload beat; a header strobe
   // seen mid-payload is still a payload beat, so it is covered either way.
   assign par_err = par_mismatch && (sii.dmu_sii_hdr_vld || in_payload);
`else
   assign par_err = 1'b0;
`endif

   // ---------------------------------------------------------------------------
   // FSM process 1: state register
   // ---------------------------------------------------------------------------
   // NOTE: sequential state is updated with non-blocking (<=) assignments so
   // every flop samples the pre-edge value of its neighbours.
   always_ff @(posedge iol2clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         beat_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM process 2: next state. Payload beats are back-to-back with no stall,
   // so the counter simply runs down from length-1 and the FSM leaves on 0.
   // ---------------------------------------------------------------------------
   // NOTE: every always_comb output gets a default on entry; a path that leaves
   // one unassigned would otherwise infer a latch.
   always_comb begin
      state_d    = state_q;
      beat_cnt_d = beat_cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (hdr_wr) begin
               state_d    = ST_WR_PAY;
               beat_cnt_d = WR_LOAD;
            end else if (hdr_mp) begin
               state_d    = ST_MP_PAY;
               beat_cnt_d = MP_LOAD;
            end
         end
         ST_WR_PAY,
         ST_MP_PAY: begin
            if (beat_cnt_q == '0) begin
               state_d = ST_IDLE;
            end else begin
               beat_cnt_d = beat_cnt_q - 1'b1;
            end
         end
         default: begin
            state_d    = ST_IDLE;
            beat_cnt_d = '0;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // FSM process 3: outputs (next values of the registered outputs)
   // ---------------------------------------------------------------------------
   always_comb begin
      ev_rd_d      = hdr_rd;
      ev_wr_d      = hdr_wr;
      ev_mondo_d   = hdr_mp && !sii.dmu_sii_reqbypass;
      ev_pio_d     = hdr_mp &&  sii.dmu_sii_reqbypass;
      ev_wr_done_d = (state_q == ST_WR_PAY) && (beat_cnt_q == '0);
      ev_mp_done_d = (state_q == ST_MP_PAY) && (beat_cnt_q == '0);

      hdr_tag_d    = hdr_tag_q;
      hdr_pa_d     = hdr_pa_q;
      if (hdr_acc) begin
         hdr_tag_d = sii.dmu_sii_data[79:64];
         hdr_pa_d  = sii.dmu_sii_data[39:0];
      end

      wrack_tag_d  = sii.sii_dmu_wrack_vld ? sii.sii_dmu_wrack_tag : wrack_tag_q;

      err_pulse_d                 = '0;
      err_pulse_d[ERR_HDR_IN_PAY] = sii.dmu_sii_hdr_vld && in_payload;
      err_pulse_d[ERR_PARITY]     = par_err;

      // Credit counter. A new write and an ack in the same cycle cancel, which
      // also suppresses both the overflow and the underflow check.
      wr_out_d = wr_out_q;
      unique case ({hdr_wr, sii.sii_dmu_wrack_vld})
         2'b10: begin
            if (wr_out_q == CNT_MAX) begin
               err_pulse_d[ERR_CREDIT_OVF] = 1'b1;
            end else begin
               wr_out_d = wr_out_q + 1'b1;
            end
         end
         2'b01: begin
            if (wr_out_q == '0) begin
               err_pulse_d[ERR_WRACK_UNF] = 1'b1;
            end else begin
               wr_out_d = wr_out_q - 1'b1;
            end
         end
         default: wr_out_d = wr_out_q;
      endcase

      // Sticky bits rise in the same cycle as the pulse that sets them.
      err_sticky_d = err_sticky_q | err_pulse_d;
   end

   // ---------------------------------------------------------------------------
   // Output registers. Reset clears everything, which also drops any pending
   // done pulse of an abandoned payload.
   // ---------------------------------------------------------------------------
   always_ff @(posedge iol2clk) begin
      if (rst) begin
         ev_rd_q      <= 1'b0;
         ev_wr_q      <= 1'b0;
         ev_mondo_q   <= 1'b0;
         ev_pio_q     <= 1'b0;
         ev_wr_done_q <= 1'b0;
         ev_mp_done_q <= 1'b0;
         hdr_tag_q    <= '0;
         hdr_pa_q     <= '0;
         wr_out_q     <= '0;
         wrack_tag_q  <= '0;
         err_pulse_q  <= '0;
         err_sticky_q <= '0;
      end else begin
         ev_rd_q      <= ev_rd_d;
         ev_wr_q      <= ev_wr_d;
         ev_mondo_q   <= ev_mondo_d;
         ev_pio_q     <= ev_pio_d;
         ev_wr_done_q <= ev_wr_done_d;
         ev_mp_done_q <= ev_mp_done_d;
         hdr_tag_q    <= hdr_tag_d;
         hdr_pa_q     <= hdr_pa_d;
         wr_out_q     <= wr_out_d;
         wrack_tag_q  <= wrack_tag_d;
         err_pulse_q  <= err_pulse_d;
         err_sticky_q <= err_sticky_d;
      end
   end

   assign ev_rd          = ev_rd_q;
   assign ev_wr          = ev_wr_q;
   assign ev_mondo       = ev_mondo_q;
   assign ev_pio         = ev_pio_q;
   assign ev_wr_done     = ev_wr_done_q;
   assign ev_mp_done     = ev_mp_done_q;
   assign hdr_tag        = hdr_tag_q;
   assign hdr_pa         = hdr_pa_q;
   assign wr_outstanding = wr_out_q;
   assign last_wrack_tag = wrack_tag_q;
   assign err_pulse      = err_pulse_q;
   assign err_sticky     = err_sticky_q;

endmodule : dmu_sii_inb_tracker

// File: doc/dmu_sii_inb_tracker.md
# dmu_sii_inb_tracker

Parametrised, synthesizable tracker for the DMU-to-SII inbound request interface. It decodes header cycles into read, write, Mondo and PIO-read-return events and sequences payload beats with an FSM. It also tracks outstanding DMA write credits against SII write acks and flags protocol violations as pulses plus sticky status. It sits passively on the `SII` boundary beside the logging monitor, and its outputs drive scoreboards, coverage and emulation assertions.

## Interface
- DATA_W, 128, data bus width; a multiple of 16
- PAR_W, DATA_W/16, parity bits, one per 16-bit lane
- WR_BEATS, 4, payload beats following a write header
- MP_BEATS, 1, payload beats following a Mondo or PIO header
- CREDITS, 16, maximum outstanding DMA writes
- CNT_W, 5, width of the outstanding counter; must satisfy 2^CNT_W > CREDITS
- iol2clk  in  1  sole clock
- rst  in  1  synchronous, active-high reset
- dmu_sii_hdr_vld, dmu_sii_reqbypass, dmu_sii_datareq, dmu_sii_datareq16  in  1 each  header qualifiers
- dmu_sii_data  in  DATA_W  header or payload
- dmu_sii_parity  in  PAR_W  lane parity
- sii_dmu_wrack_vld  in  1  write credit return
- sii_dmu_wrack_tag  in  4  returned tag
- ev_rd, ev_wr, ev_mondo, ev_pio  out  1 each  header-decoded pulses
- ev_wr_done, ev_mp_done  out  1 each  last-payload-beat pulses
- hdr_tag  out  16  dmu_sii_data[79:64] of the last accepted header
- hdr_pa  out  40  dmu_sii_data[39:0] of the last accepted header
- wr_outstanding  out  CNT_W  in-flight DMA writes
- last_wrack_tag  out  4  tag of the most recent ack
- err_pulse  out  4  {parity, wrack_underflow, credit_overflow, hdr_in_payload}
- err_sticky  out  4  OR-accumulated err_pulse

## Operation
- Header decode applies when dmu_sii_hdr_vld=1 and the FSM is IDLE:
  - {datareq, datareq16} = 00 → read; no payload follows.
  - 10 → write; go to WR_PAY.
  - 11 with reqbypass=0 → Mondo; go to MP_PAY.
  - 11 with reqbypass=1 → PIO read return; go to MP_PAY.
  - 01 → treated as read.
- Every accepted header loads hdr_tag and hdr_pa.
- FSM states are IDLE, WR_PAY and MP_PAY. A beat counter is loaded with WR_BEATS-1 or MP_BEATS-1 on entry and decrements once per cycle. At count 0 the FSM returns to IDLE.
- Payload beats are unconditional consecutive cycles; there is no stall.
- hdr_vld=1 in WR_PAY or MP_PAY pulses err[0]. The header is ignored and the FSM continues.
- Outstanding credit:
  - A write header increments wr_outstanding. sii_dmu_wrack_vld decrements it. Both in the same cycle leave it unchanged.
  - Increment at count==CREDITS (without a simultaneous ack) pulses err[1]; the count saturates.
  - Ack at count 0 (without a simultaneous increment) pulses err[2]; the count stays 0.
  - Every ack loads last_wrack_tag.
- datareq or datareq16 without hdr_vld in IDLE is ignored.
- err_sticky[i] sets whenever err_pulse[i] fires and clears only on rst.

## Timing
- All outputs are registered.
- Every event and err_pulse output asserts exactly 1 cycle after its causing input cycle and lasts 1 cycle.
- Header is at cycle H:
  - write payload occupies H+1..H+WR_BEATS, and ev_wr_done fires at H+WR_BEATS+1;
  - Mondo/PIO payload occupies H+1..H+MP_BEATS, and ev_mp_done fires at H+MP_BEATS+1.
- A back-to-back header at the cycle after the last beat is accepted.
- wr_outstanding updates 1 cycle after the header or ack.
- On rst:
  - all outputs go to 0, including hdr_tag, hdr_pa, last_wrack_tag and err_sticky;
  - the FSM goes to IDLE and the counters clear.
- Reset mid-payload abandons the payload; no done pulse is generated.

## Configuration
- DMU_SII_INB_PARCHK_EN defined: on every header and payload cycle, even parity is checked per lane. The required relation is parity[i] = ^data[16i+15:16i]. Any mismatch pulses err[3].
- Not defined: the checker logic is absent, and err_pulse[3] and err_sticky[3] are tied 0.

## Test plan
- Read header with {00}, reqbypass=0, data[79:64]=16'h00A5, data[39:0]=40'h12_3456_7890 → ev_rd at H+1, hdr_tag=00A5, hdr_pa=1234567890, FSM stays IDLE.
- Write header followed by 4 beats, then a read header at H+5 → ev_wr at H+1, ev_wr_done at H+5, ev_rd at H+6, wr_outstanding=1.
- Write header followed by 4 beats, then a wrack (tag 4'h7) at H+7 → wr_outstanding returns to 0 at H+8, last_wrack_tag=7. A wrack with no outstanding writes → err_pulse[2] for 1 cycle and err_sticky[2]=1.
- 17 write transactions with no acks → err_pulse[1] on the 17th, wr_outstanding held at 16. A header plus an ack in the same cycle at count 16 → no error, count 16.
- Mondo header (11, bypass 0), then hdr_vld reasserted at H+1 with MP_BEATS=1 → ev_mondo, err_pulse[0] at H+2, ev_mp_done at H+2. PIO header (11, bypass 1) → ev_pio.
- With PARCHK_EN, write payload beat 2 with parity[0] flipped → err_pulse[3] the cycle after that beat. Reset asserted at beat 3 → no ev_wr_done and all outputs 0.
